// File: rtl/seq_serializer.sv
// seq_serializer: double-buffered parallel-to-serial converter with a word counter
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             busy,
    output logic             last,
    output logic [7:0]       words_sent
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;

    always_comb begin
        busy = state == SHIFT;
        last = busy && cnt == CW'(WIDTH - 1);
        w = busy && (MSB_FIRST != 0 ? shreg[WIDTH-1] : shreg[0]);
        ready = rst && !hold_full;
        shifted = MSB_FIRST != 0 ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            hold <= '0;
            hold_full <= 1'b0;
            shreg <= '0;
            cnt <= '0;
            words_sent <= '0;
        end else begin
            if (load && ready) begin
                hold <= data_in;
                hold_full <= 1'b1;
            end
            if (state == IDLE) begin
                if (hold_full) begin
                    shreg <= hold;
                    hold_full <= 1'b0;
                    cnt <= '0;
                    state <= SHIFT;
                end
            end else if (last) begin
                words_sent <= words_sent + 8'd1;
                if (hold_full) begin
                    shreg <= hold;
                    hold_full <= 1'b0;
                    cnt <= '0;
                end else begin
                    state <= IDLE;
                end
            end else begin
                shreg <= shifted;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, 8, number of bits per word; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, 1, serial bit order: 1 sends the MSB first, 0 sends the LSB first.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 data_in  input  WIDTH  parallel word to serialize.
REQ-006 load  input  1  word-valid strobe; a word SHALL be accepted only when load=1 and ready=1 at a rising edge.
REQ-007 ready  output  1  holding register empty: ready = !hold_full, and 0 while rst=0.
REQ-008 w  output  1  serial bit stream that drives the downstream sequence detector's w input.
REQ-009 busy  output  1  high while the FSM is in SHIFT.
REQ-010 last  output  1  high during the cycle in which the final bit of a word is on w.
REQ-011 words_sent  output  8  count of completed words; wraps from 255 to 0.

Function
REQ-012 Storage: one holding register (hold, hold_full), one shift register (shreg), and a bit counter cnt of width clog2(WIDTH).
REQ-013 Accepting a word SHALL load data_in into hold and set hold_full=1.
REQ-014 load with ready=0 SHALL be ignored; data_in is dropped and no state changes.
REQ-015 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-016 IDLE: w=0, busy=0, last=0.
REQ-017 IDLE with hold_full=1 at an edge: shreg<=hold, hold_full<=0, cnt<=0, next state SHIFT.
REQ-018 SHIFT: w SHALL be shreg[WIDTH-1] when MSB_FIRST=1, or shreg[0] when MSB_FIRST=0.
REQ-019 SHIFT with cnt<WIDTH-1 at each edge: shreg shifts by one toward the output bit, and cnt increments.
REQ-020 SHIFT with cnt==WIDTH-1: last SHALL be 1 for that cycle.
REQ-021 At the edge ending a last=1 cycle, words_sent SHALL increment by 1.
REQ-022 At the edge ending a last=1 cycle with hold_full=1: shreg<=hold, hold_full<=0, cnt<=0, and the FSM stays in SHIFT, so the next word follows with no idle bit.
REQ-023 At the edge ending a last=1 cycle with hold_full=0: the FSM SHALL go to IDLE, and w SHALL be 0 in the next cycle.
REQ-024 Latency: a word accepted at edge N SHALL have its first bit on w in the cycle after edge N+1, provided the FSM was IDLE at edge N.
REQ-025 Simultaneous transfer and load cannot occur, because ready=0 whenever hold_full=1; no bypass path exists from data_in to shreg.
REQ-026 w, busy and last SHALL be pure functions of registered state and SHALL contain no combinational path from load or data_in.

Reset
REQ-027 rst=0 at an edge SHALL force state=IDLE, hold_full=0, hold=0, shreg=0, cnt=0 and words_sent=0.
REQ-028 Following a reset edge, w, busy and last SHALL all be 0.
REQ-029 ready SHALL be 0 while rst=0, and 1 in the first cycle after rst returns to 1.
REQ-030 Reset asserted mid-word SHALL abort the word and discard any held word; words_sent SHALL NOT increment for the aborted word.
REQ-031 A load coincident with an rst=0 edge SHALL be ignored.

Verification
REQ-032 Single word: WIDTH=8, MSB_FIRST=1, load data_in=8'hB2 in cycle 0.
  - Required: w=1,0,1,1,0,0,1,0 in cycles 2-9.
  - Required: last=1 only in cycle 9, and busy=1 in cycles 2-9.
  - Required: w=0 from cycle 10 and words_sent=1.
REQ-033 Back-to-back: load 8'hB2 in cycle 0 and 8'h0F in cycle 2 (ready=1 in cycle 2).
  - Required: w in cycles 10-17 is 0,0,0,0,1,1,1,1, with no gap.
  - Required: words_sent=2 after cycle 17.
REQ-034 Overrun: load 8'hFF in cycle 1 while ready=0.
  - Required: the word is dropped; w never carries 8'hFF, and words_sent counts only accepted words.
REQ-035 LSB-first: MSB_FIRST=0, load 8'h01.
  - Required: w=1 in the first bit cycle, then 0 for the remaining 7 bit cycles.
REQ-036 Mid-word reset: rst=0 at the edge ending cycle 5 of the REQ-032 stream.
  - Required: w=0, busy=0, ready=0 and words_sent=0 in cycle 6.
  - Required: ready=1 in the cycle after rst=1.
REQ-037 Wrap: send 256 words back-to-back.
  - Required: words_sent reads 255, then 0.
  - Required: no bit gaps between consecutive words.
